// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM-backed streaming FIFO.
// Defines the op encoding and the width of the output-buffer credit check.
package sram_pkg;

    typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} sram_op_t;

    // Wide enough to hold any occupancy count from 0 to depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram_ob_fifo.sv
// Small synchronous FIFO that absorbs SRAM read responses ahead of the output stream.
// Storage is registered; the head word drives data_o directly.
module sram_ob_fifo
    import sram_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DW-1:0]                data_i,
    input  logic                         pop_i,
    output logic [DW-1:0]                data_o,
    output logic                         valid_o,
    output logic [credit_w(DEPTH)-1:0]   count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = credit_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_idx_d = push_i ? wr_idx_q + PW'(1) : wr_idx_q;
        rd_idx_d = pop_i ? rd_idx_q + PW'(1) : rd_idx_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_idx_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_idx_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/sram_stream_fifo.sv
// Streaming FIFO backed by the external SRAM through the arbiter user port.
// Owns the write/read pointers, stored-word level, read tag pipe and output buffer.
module sram_stream_fifo
    import sram_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 19,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned OB_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          err_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_wr_o,
    input  logic [DW-1:0] data_rd_i,
    output logic          en_o,
    input  logic          busy_i,
    output logic          we_o,
    input  logic          valid_i
);
    localparam int unsigned CW = credit_w(OB_DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              last_wr_q, last_wr_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic              err_q, err_d;
    logic [CW-1:0]     ob_count, inflight;
    logic [CW:0]       credit;
    logic              full, wr_elig, rd_elig, ob_push, ob_pop, ob_valid;
    sram_op_t          op;

    // Level can only reach 2**AW, so its top bit alone marks full.
    assign full    = level_q[AW];
    assign credit  = {1'b0, ob_count} + {1'b0, inflight};
    assign ob_push = tag_q[RD_LAT-1];
    assign ob_pop  = ob_valid & m_ready_i;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(tag_q[i]);
        end
    end

    // Reads win when the output side is starving, otherwise grants alternate.
    always_comb begin
        wr_elig = s_valid_i & ~full;
        rd_elig = (level_q != '0) && (credit < (CW + 1)'(OB_DEPTH));
        op      = OP_IDLE;
        if (rst_ni && !busy_i) begin
            if (wr_elig && rd_elig) begin
                op = ((credit == '0) || last_wr_q) ? OP_RD : OP_WR;
            end else if (wr_elig) begin
                op = OP_WR;
            end else if (rd_elig) begin
                op = OP_RD;
            end
        end
    end

    always_comb begin
        en_o      = (op != OP_IDLE);
        we_o      = (op == OP_WR);
        s_ready_o = (op == OP_WR);
        addr_o    = '0;
        data_wr_o = '0;
        case (op)
            OP_WR: begin
                addr_o    = wr_ptr_q;
                data_wr_o = s_data_i;
            end
            OP_RD:   addr_o = rd_ptr_q;
            default: addr_o = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        last_wr_d = last_wr_q;
        case (op)
            OP_WR: begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                level_d   = level_q + (AW + 1)'(1);
                last_wr_d = 1'b1;
            end
            OP_RD: begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                level_d   = level_q - (AW + 1)'(1);
                last_wr_d = 1'b0;
            end
            default: last_wr_d = last_wr_q;
        endcase
        tag_d[0] = (op == OP_RD);
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        err_d = err_q | (ob_push & ~valid_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            last_wr_q <= 1'b0;
            tag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            last_wr_q <= last_wr_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
        end
    end

    sram_ob_fifo #(
        .DW    (DW),
        .DEPTH (OB_DEPTH)
    ) u_ob (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ob_push),
        .data_i  (data_rd_i),
        .pop_i   (ob_pop),
        .data_o  (m_data_o),
        .valid_o (ob_valid),
        .count_o (ob_count)
    );

    assign m_valid_o = ob_valid;
    assign level_o   = level_q;
    assign full_o    = full;
    assign err_o     = err_q;

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Bench for sram_stream_fifo: behavioural SRAM/arbiter model plus a FIFO-order scoreboard.
module tb_sram_stream_fifo;
    localparam int unsigned DW = 8, AW = 4, RD_LAT = 2, OB_DEPTH = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] s_data = '0, m_data, data_wr;
    logic [DW-1:0] data_rd = '0;
    logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
    logic [AW:0] level;
    logic full, err, en, we, busy = 1'b0, valid = 1'b0;
    logic [AW-1:0] addr;

    int n_vec = 0, n_err = 0;
    logic [DW-1:0] mem [DEPTH];
    logic          pv [RD_LAT] = '{default: 1'b0};
    logic [DW-1:0] pd [RD_LAT] = '{default: '0};
    logic          cur_v = 1'b0;
    logic [DW-1:0] cur_d = '0;
    bit            force_bad = 1'b0;
    logic [DW-1:0] got_q[$], sent_q[$];
    logic [AW-1:0] wr_addr_q[$];
    int            rd_cnt = 0;

    sram_stream_fifo #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .OB_DEPTH(OB_DEPTH)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .level_o(level), .full_o(full), .err_o(err), .addr_o(addr), .data_wr_o(data_wr),
        .data_rd_i(data_rd), .en_o(en), .busy_i(busy), .we_o(we), .valid_i(valid)
    );

    always #5 clk = ~clk;

    // Mid-cycle: perform the SRAM op and record handshakes.
    always @(negedge clk) begin
        cur_v = en;
        cur_d = '0;
        if (en && we) begin
            mem[addr] = data_wr;
            wr_addr_q.push_back(addr);
        end
        if (en && !we) begin
            cur_d = mem[addr];
            rd_cnt++;
        end
        if (m_valid && m_ready) got_q.push_back(m_data);
    end

    // Response for every op appears RD_LAT cycles after its en.
    always @(posedge clk) begin
        #1;
        for (int k = RD_LAT - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0]   = cur_v;
        pd[0]   = cur_d;
        valid   = pv[RD_LAT-1] & ~force_bad;
        data_rd = pd[RD_LAT-1];
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; busy = 1'b0; force_bad = 1'b0;
        tick();
        tick();
        got_q.delete(); sent_q.delete(); wr_addr_q.delete(); rd_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 300 && !done; n++) begin
            #1;
            done = s_ready;
            tick();
        end
        s_valid = 1'b0;
        if (done) sent_q.push_back(d);
        else begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: word %0h not accepted, expected acceptance", d);
        end
    endtask

    task automatic drain_to(input int n);
        m_ready = 1'b1;
        for (int c = 0; c < 2000 && got_q.size() < n; c++) tick();
        m_ready = 1'b0;
        if (got_q.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d words, expected %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        tick();
        #1;
        n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %0h, expected 0", en); end
        n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h, expected 0", we); end
        n_vec++; if (addr !== '0) begin n_err++; $display("FAIL rst_addr: got %0h, expected 0", addr); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %0h, expected 0", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %0h, expected 0", m_valid); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0h, expected 0", full); end
        n_vec++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d, expected 0", level); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0h, expected 0", err); end
        s_valid = 1'b0; m_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL idle_en: got %0h, expected 0", en); end
        s_valid = 1'b1;
        #1;
        n_vec++; if ({en, we, s_ready} !== 3'b111) begin
            n_err++; $display("FAIL first_wr: got en/we/s_ready %b, expected 111", {en, we, s_ready});
        end
        n_vec++; if (data_wr !== 8'hA5) begin n_err++; $display("FAIL first_data_wr: got %0h, expected a5", data_wr); end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] w [3] = '{8'h11, 8'h22, 8'h33};
        apply_reset();
        for (int i = 0; i < 3; i++) send(w[i]);
        repeat (8) tick();
        n_vec++; if (wr_addr_q.size() != 3) begin n_err++; $display("FAIL basic_nwr: got %0d writes, expected 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            n_vec++; if (wr_addr_q[i] !== AW'(i)) begin n_err++; $display("FAIL basic_addr: got %0d, expected %0d", wr_addr_q[i], i); end
        end
        n_vec++; if (level !== 0) begin n_err++; $display("FAIL basic_level: got %0d, expected 0", level); end
        n_vec++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            n_err++; $display("FAIL basic_head: got valid %0h data %0h, expected 1/11", m_valid, m_data);
        end
        drain_to(3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== w[i]) begin n_err++; $display("FAIL basic_out: got %0h, expected %0h", got_q[i], w[i]); end
        end
        tick();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %0h, expected 0", m_valid); end
    endtask

    task automatic test_credit();
        apply_reset();
        for (int i = 0; i < 14; i++) send(DW'(8'h40 + i));
        repeat (10) tick();
        n_vec++; if (rd_cnt != OB_DEPTH) begin n_err++; $display("FAIL credit_reads: got %0d, expected %0d", rd_cnt, OB_DEPTH); end
        n_vec++; if (level !== 10) begin n_err++; $display("FAIL credit_level: got %0d, expected 10", level); end
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL credit_en_idle: got %0h, expected 0", en); end
            tick();
        end
        drain_to(1);
        repeat (10) tick();
        n_vec++; if (rd_cnt != OB_DEPTH + 1) begin n_err++; $display("FAIL credit_refill: got %0d, expected %0d", rd_cnt, OB_DEPTH + 1); end
        n_vec++; if (level !== 9) begin n_err++; $display("FAIL credit_level2: got %0d, expected 9", level); end
        n_vec++; if (got_q.size() < 1 || got_q[0] !== 8'h40) begin n_err++; $display("FAIL credit_out: got %0h, expected 40", got_q[0]); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < int'(DEPTH + OB_DEPTH); i++) send(DW'(8'h80 + i));
        repeat (6) tick();
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL wrap_full: got %0h, expected 1", full); end
        n_vec++; if (level !== DEPTH) begin n_err++; $display("FAIL wrap_level: got %0d, expected %0d", level, DEPTH); end
        s_valid = 1'b1; s_data = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (s_ready !== 1'b0 || en !== 1'b0) begin
                n_err++; $display("FAIL wrap_blocked: got s_ready %0h en %0h, expected 0/0", s_ready, en);
            end
            tick();
        end
        s_valid = 1'b0;
        drain_to(8);
        for (int i = 0; i < 8; i++) send(DW'(8'h80 + DEPTH + OB_DEPTH + i));
        drain_to(sent_q.size());
        for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== sent_q[i]) begin n_err++; $display("FAIL wrap_out[%0d]: got %0h, expected %0h", i, got_q[i], sent_q[i]); end
        end
        n_vec++; if (wr_addr_q.size() != sent_q.size()) begin
            n_err++; $display("FAIL wrap_nwr: got %0d, expected %0d", wr_addr_q.size(), sent_q.size());
        end
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_vec++; if (wr_addr_q[i] !== AW'(i % DEPTH)) begin
                n_err++; $display("FAIL wrap_addr[%0d]: got %0d, expected %0d", i, wr_addr_q[i], i % DEPTH);
            end
        end
        n_vec++; if (level !== 0 || full !== 1'b0) begin n_err++; $display("FAIL wrap_end: got level %0d full %0h, expected 0/0", level, full); end
    endtask

    task automatic test_busy();
        apply_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(DW'(8'hC0 + i));
        busy = 1'b1; s_valid = 1'b1; s_data = 8'hC6;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (en !== 1'b0 || s_ready !== 1'b0) begin
                n_err++; $display("FAIL busy_hold: got en %0h s_ready %0h, expected 0/0", en, s_ready);
            end
            tick();
        end
        busy = 1'b0; s_valid = 1'b0;
        for (int i = 6; i < 12; i++) send(DW'(8'hC0 + i));
        drain_to(12);
        n_vec++; if (got_q.size() != 12) begin n_err++; $display("FAIL busy_count: got %0d, expected 12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== DW'(8'hC0 + i)) begin n_err++; $display("FAIL busy_out[%0d]: got %0h, expected %0h", i, got_q[i], 8'hC0 + i); end
        end
    endtask

    task automatic test_err();
        apply_reset();
        force_bad = 1'b1;
        send(8'h5A);
        repeat (6) tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %0h, expected 1", err); end
        n_vec++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
            n_err++; $display("FAIL err_data: got valid %0h data %0h, expected 1/5a", m_valid, m_data);
        end
        force_bad = 1'b0;
        for (int i = 0; i < 5; i++) send(DW'(8'h60 + i));
        repeat (8) tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %0h, expected 1", err); end
        n_vec++; if (level !== 2) begin n_err++; $display("FAIL err_level: got %0d, expected 2", level); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (err !== 1'b0 || level !== 0 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL err_async_rst: got err %0h level %0d m_valid %0h, expected 0/0/0", err, level, m_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_after_rst: got %0h, expected 0", err); end
    endtask

    task automatic test_random();
        int sent = 0, busy_viol = 0, cyc = 0;
        localparam int N = 10000;
        apply_reset();
        for (cyc = 0; cyc < 85000 && got_q.size() < N; cyc++) begin
            s_valid = (sent < N) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data  = DW'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            busy    = ($urandom_range(0, 15) == 0);
            #1;
            if (busy && en) busy_viol++;
            if (s_valid && s_ready) begin
                sent_q.push_back(s_data);
                sent++;
            end
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0; busy = 1'b0;
        n_vec++; if (got_q.size() != N) begin n_err++; $display("FAIL rand_count: got %0d words, expected %0d", got_q.size(), N); end
        n_vec++; if (busy_viol != 0) begin n_err++; $display("FAIL rand_en_busy: got %0d cycles, expected 0", busy_viol); end
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            n_vec++; if (got_q[i] !== sent_q[i]) begin n_err++; $display("FAIL rand_out[%0d]: got %0h, expected %0h", i, got_q[i], sent_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_wrap();
        test_busy();
        test_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
